// File: rtl/test_monitor_pkg.sv
// Shared state encoding and width helpers for the multi-channel test sequence monitor.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PASSED  = 2'd2,
    ST_FAILED  = 2'd3
  } chan_state_e;

  localparam int STATE_W = 2;

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_sequence_monitor_if.sv
// Control/status bundle between firmware-facing GPIO logic and the test sequence monitor.
// Optional macro: TEST_MONITOR_CONTINUE_ON_FAIL_EN adds the per-channel fail totals.
interface test_sequence_monitor_if
  import test_monitor_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 24
);
  localparam int CH_W = idx_width(CHANNELS);

  logic                              enable_i;
  logic                              clear_i;
  logic [COUNT_WIDTH-1:0]            expected_count_i;
  logic [TIMEOUT_WIDTH-1:0]          timeout_cycles_i;
  logic [CHANNELS-1:0]               success_i;
  logic [CHANNELS-1:0]               next_test_i;
  logic [CHANNELS*COUNT_WIDTH-1:0]   test_count_o;
  logic [CHANNELS*STATE_W-1:0]       chan_state_o;
  logic [CHANNELS-1:0]               timeout_flag_o;
  logic                              done_o;
  logic                              pass_o;
  logic                              fail_o;
  logic [CH_W-1:0]                   fail_channel_o;
  logic [COUNT_WIDTH-1:0]            fail_index_o;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
  logic [CHANNELS*COUNT_WIDTH-1:0]   fail_total_o;
`endif

  modport master (
    output enable_i, clear_i, expected_count_i, timeout_cycles_i, success_i, next_test_i,
    input  test_count_o, chan_state_o, timeout_flag_o, done_o, pass_o, fail_o,
           fail_channel_o, fail_index_o
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
    , input fail_total_o
`endif
  );

  modport slave (
    input  enable_i, clear_i, expected_count_i, timeout_cycles_i, success_i, next_test_i,
    output test_count_o, chan_state_o, timeout_flag_o, done_o, pass_o, fail_o,
           fail_channel_o, fail_index_o
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
    , output fail_total_o
`endif
  );

endinterface

// File: rtl/test_channel_fsm.sv
// One monitored channel: input synchronisers, next_test edge detect, test FSM, counter, watchdog.
// Optional macro: TEST_MONITOR_CONTINUE_ON_FAIL_EN keeps running after a failed test.
module test_channel_fsm
  import test_monitor_pkg::*;
#(
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [COUNT_WIDTH-1:0]   expected_in,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_in,
  input  logic                     success_async,
  input  logic                     next_async,
  output chan_state_e              state,
  output logic [COUNT_WIDTH-1:0]   count,
  output logic                     failed,
  output logic                     timeout_flag,
  output logic [COUNT_WIDTH-1:0]   fail_idx
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
  , output logic [COUNT_WIDTH-1:0] fail_total
`endif
);

  logic [SYNC_STAGES-1:0]   succ_sync, next_sync;
  logic                     next_prev, evt, succ;
  chan_state_e              state_nx;
  logic [COUNT_WIDTH-1:0]   count_nx, cnt_inc, exp_q, exp_nx, fidx_nx;
  logic [TIMEOUT_WIDTH-1:0] wd, wd_nx, wd_inc, to_q, to_nx;
  logic                     failed_nx, tflag_nx;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
  logic [COUNT_WIDTH-1:0]   ftot_q, ftot_nx, ftot_inc;
  assign ftot_inc   = ftot_q + COUNT_WIDTH'(1);
  assign fail_total = ftot_q;
`endif

  // Both strobes share one synchroniser depth so success stays aligned with its event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      succ_sync <= '0;
      next_sync <= '0;
      next_prev <= 1'b0;
    end else begin
      succ_sync <= {succ_sync[SYNC_STAGES-2:0], success_async};
      next_sync <= {next_sync[SYNC_STAGES-2:0], next_async};
      next_prev <= next_sync[SYNC_STAGES-1];
    end
  end

  assign evt     = next_sync[SYNC_STAGES-1] & ~next_prev;
  assign succ    = succ_sync[SYNC_STAGES-1];
  assign cnt_inc = count + COUNT_WIDTH'(1);
  assign wd_inc  = wd + TIMEOUT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      count        <= '0;
      wd           <= '0;
      exp_q        <= '0;
      to_q         <= '0;
      failed       <= 1'b0;
      timeout_flag <= 1'b0;
      fail_idx     <= '0;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
      ftot_q       <= '0;
`endif
    end else begin
      state        <= state_nx;
      count        <= count_nx;
      wd           <= wd_nx;
      exp_q        <= exp_nx;
      to_q         <= to_nx;
      failed       <= failed_nx;
      timeout_flag <= tflag_nx;
      fail_idx     <= fidx_nx;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
      ftot_q       <= ftot_nx;
`endif
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = count;
    wd_nx     = wd;
    exp_nx    = exp_q;
    to_nx     = to_q;
    failed_nx = failed;
    tflag_nx  = timeout_flag;
    fidx_nx   = fail_idx;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
    ftot_nx   = ftot_q;
`endif
    if (clear) begin
      state_nx  = ST_IDLE;
      count_nx  = '0;
      wd_nx     = '0;
      failed_nx = 1'b0;
      tflag_nx  = 1'b0;
      fidx_nx   = '0;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
      ftot_nx   = '0;
`endif
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          exp_nx   = expected_in;
          to_nx    = timeout_in;
          wd_nx    = '0;
          state_nx = (expected_in == '0) ? ST_PASSED : ST_RUNNING;
        end
        ST_RUNNING: begin
          if (evt) begin
            wd_nx = '0;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
            count_nx = cnt_inc;
            if (!succ) begin
              ftot_nx = ftot_inc;
              if (!failed) begin
                failed_nx = 1'b1;
                fidx_nx   = count;
              end
            end
            if (cnt_inc == exp_q) state_nx = (ftot_nx == '0) ? ST_PASSED : ST_FAILED;
`else
            if (succ) begin
              count_nx = cnt_inc;
              if (cnt_inc == exp_q) state_nx = ST_PASSED;
            end else begin
              state_nx  = ST_FAILED;
              failed_nx = 1'b1;
              fidx_nx   = count;
            end
`endif
          end else if ((to_q != '0) && (wd_inc == to_q)) begin
            // Event has priority, so the watchdog only trips on an event-free cycle.
            state_nx  = ST_FAILED;
            tflag_nx  = 1'b1;
            failed_nx = 1'b1;
            if (!failed) fidx_nx = count;
          end else begin
            wd_nx = wd_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/test_sequence_monitor.sv
// Multi-channel silicon self-test monitor: per-channel FSMs plus aggregate pass/fail/done.
// Optional macro: TEST_MONITOR_CONTINUE_ON_FAIL_EN (run-through on failure, fail totals).
module test_sequence_monitor
  import test_monitor_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int COUNT_WIDTH   = 8,
  parameter int TIMEOUT_WIDTH = 24,
  parameter int SYNC_STAGES   = 2
) (
  input logic                    wb_clk_i,
  input logic                    wb_rst_i,
  test_sequence_monitor_if.slave bus
);

  localparam int CH_W = idx_width(CHANNELS);

  chan_state_e                            ch_state [CHANNELS];
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0]   ch_count, ch_fidx;
  logic [CHANNELS-1:0][STATE_W-1:0]       st_bits;
  logic [CHANNELS-1:0]                    ch_failed, ch_tflag, term, passed;
  logic [CH_W-1:0]                        first_ch, fch_q;
  logic [COUNT_WIDTH-1:0]                 fidx_q;
  logic                                   done_q, pass_q, fail_q;
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
  logic [CHANNELS-1:0][COUNT_WIDTH-1:0]   ch_ftot;
  assign bus.fail_total_o = ch_ftot;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    test_channel_fsm #(
      .COUNT_WIDTH  (COUNT_WIDTH),
      .TIMEOUT_WIDTH(TIMEOUT_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES)
    ) u_ch (
      .clk          (wb_clk_i),
      .rst          (wb_rst_i),
      .enable       (bus.enable_i),
      .clear        (bus.clear_i),
      .expected_in  (bus.expected_count_i),
      .timeout_in   (bus.timeout_cycles_i),
      .success_async(bus.success_i[g]),
      .next_async   (bus.next_test_i[g]),
      .state        (ch_state[g]),
      .count        (ch_count[g]),
      .failed       (ch_failed[g]),
      .timeout_flag (ch_tflag[g]),
      .fail_idx     (ch_fidx[g])
`ifdef TEST_MONITOR_CONTINUE_ON_FAIL_EN
      , .fail_total (ch_ftot[g])
`endif
    );
    assign term[g]    = (ch_state[g] == ST_PASSED) || (ch_state[g] == ST_FAILED);
    assign passed[g]  = (ch_state[g] == ST_PASSED);
    assign st_bits[g] = ch_state[g];
  end

  // Lowest-numbered failing channel wins a simultaneous failure.
  always_comb begin
    first_ch = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (ch_failed[i]) first_ch = CH_W'(i);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      fch_q  <= '0;
      fidx_q <= '0;
    end else if (bus.clear_i) begin
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      fch_q  <= '0;
      fidx_q <= '0;
    end else begin
      done_q <= &term;
      pass_q <= &passed;
      fail_q <= |ch_failed;
      if (!fail_q && |ch_failed) begin
        fch_q  <= first_ch;
        fidx_q <= ch_fidx[first_ch];
      end
    end
  end

  assign bus.test_count_o   = ch_count;
  assign bus.chan_state_o   = st_bits;
  assign bus.timeout_flag_o = ch_tflag;
  assign bus.done_o         = done_q;
  assign bus.pass_o         = pass_q;
  assign bus.fail_o         = fail_q;
  assign bus.fail_channel_o = fch_q;
  assign bus.fail_index_o   = fidx_q;

endmodule
